direction_input: RTL and testbench



---
 rtl/game2048_pkg.sv | 28 ++
 rtl/key_debounce.sv | 49 ++++
 rtl/direction_input.sv | 127 ++++++++++++
 tb/tb_direction_input.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/game2048_pkg.sv
// Shared definitions for the 2048 game: one-hot direction codes and the input FSM states.
package game2048_pkg;

    localparam int unsigned DIR_W = 4;

    localparam logic [DIR_W-1:0] DIR_UP    = 4'b1000;
    localparam logic [DIR_W-1:0] DIR_DOWN  = 4'b0100;
    localparam logic [DIR_W-1:0] DIR_LEFT  = 4'b0010;
    localparam logic [DIR_W-1:0] DIR_RIGHT = 4'b0001;

    typedef enum logic [1:0] {
        IDLE,
        PRESENT,
        RELEASE
    } dir_state_e;

    // Highest-priority pressed key as a one-hot token: up > down > left > right.
    function automatic logic [DIR_W-1:0] pick_dir(input logic [DIR_W-1:0] keys);
        logic [DIR_W-1:0] res;
        res = '0;
        if (keys[3])      res = DIR_UP;
        else if (keys[2]) res = DIR_DOWN;
        else if (keys[1]) res = DIR_LEFT;
        else if (keys[0]) res = DIR_RIGHT;
        return res;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Single-key 2-flop synchroniser plus debounce counter; key_db is the active-high pressed level.
module key_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
    input  logic clock,
    input  logic resetn,
    input  logic key_n,
    output logic key_db
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q, sync_d;
    logic             db_q, db_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pressed;

    always_comb begin
        sync_d  = {sync_q[0], key_n};
        db_d    = db_q;
        cnt_d   = cnt_q;
        pressed = ~sync_q[1];
        // Toggle only after DEBOUNCE_CYCLES consecutive differing samples.
        if (pressed == db_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            db_d  = ~db_q;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sync_q <= 2'b11;
            db_q   <= 1'b0;
            cnt_q  <= '0;
        end else begin
            sync_q <= sync_d;
            db_q   <= db_d;
            cnt_q  <= cnt_d;
        end
    end

    assign key_db = db_q;

endmodule

// File: rtl/direction_input.sv
// Debounced key-press to one-hot direction token on a valid/ready handshake.
// Optional auto-repeat while the key is held: define AUTO_REPEAT_EN.
module direction_input
    import game2048_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned REPEAT_CYCLES   = 25000000
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic [DIR_W-1:0] key_n,
    input  logic             dir_ready,
    output logic             dir_valid,
    output logic [DIR_W-1:0] dir,
    output logic [DIR_W-1:0] keys_db
);

    if (DEBOUNCE_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_param
        $error("direction_input: DEBOUNCE_CYCLES and REPEAT_CYCLES must be >= 1");
    end

    for (genvar g = 0; g < int'(DIR_W); g++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_key_debounce (
            .clock (clock),
            .resetn(resetn),
            .key_n (key_n[g]),
            .key_db(keys_db[g])
        );
    end

    dir_state_e       state_q, state_d;
    logic             valid_q, valid_d;
    logic [DIR_W-1:0] dir_q, dir_d;

`ifdef AUTO_REPEAT_EN
    localparam int unsigned HOLD_W = $clog2(REPEAT_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(REPEAT_CYCLES - 1);

    logic [DIR_W-1:0]  last_q, last_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              held;

    assign held = |(keys_db & last_q);
`endif

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        dir_d   = dir_q;
`ifdef AUTO_REPEAT_EN
        last_d  = last_q;
        hold_d  = hold_q;
        // Hold time counts from the start of the offer, so repeats are REPEAT_CYCLES apart.
        if (state_q != IDLE) begin
            if (!held)                   hold_d = '0;
            else if (hold_q != HOLD_LAST) hold_d = hold_q + HOLD_W'(1);
        end
`endif
        unique case (state_q)
            IDLE: begin
                if (keys_db != '0) begin
                    valid_d = 1'b1;
                    dir_d   = pick_dir(keys_db);
                    state_d = PRESENT;
`ifdef AUTO_REPEAT_EN
                    last_d  = pick_dir(keys_db);
                    hold_d  = '0;
`endif
                end
            end
            PRESENT: begin
                if (dir_ready) begin
                    valid_d = 1'b0;
                    dir_d   = '0;
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
`ifdef AUTO_REPEAT_EN
                if (held && hold_q == HOLD_LAST) begin
                    valid_d = 1'b1;
                    dir_d   = last_q;
                    hold_d  = '0;
                    state_d = PRESENT;
                end else if (keys_db == '0) begin
                    state_d = IDLE;
                end
`else
                if (keys_db == '0) begin
                    state_d = IDLE;
                end
`endif
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
                dir_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            dir_q   <= '0;
`ifdef AUTO_REPEAT_EN
            last_q  <= '0;
            hold_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            dir_q   <= dir_d;
`ifdef AUTO_REPEAT_EN
            last_q  <= last_d;
            hold_q  <= hold_d;
`endif
        end
    end

    assign dir_valid = valid_q;
    assign dir       = dir_q;

endmodule

// File: tb/tb_direction_input.sv
// Bench for direction_input: directed vector table, hand-written corner sequences and
// randomized key activity compared against a press-level behavioural model.
module tb_direction_input;

    localparam int DB = 4;

    logic       clock;
    logic       resetn;
    logic [3:0] key_n;
    logic       dir_ready;
    logic       dir_valid;
    logic [3:0] dir;
    logic [3:0] keys_db;

    int total = 0;
    int bad   = 0;

    direction_input #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_CYCLES  (20)
    ) dut (
        .clock    (clock),
        .resetn   (resetn),
        .key_n    (key_n),
        .dir_ready(dir_ready),
        .dir_valid(dir_valid),
        .dir      (dir),
        .keys_db  (keys_db)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural model: key levels seen two edges late, a key flips its debounced level
    // after DB consecutive disagreeing samples, and one token is issued per press episode.
    logic [3:0] m_raw1, m_raw2;
    int         m_run [4];
    logic [3:0] m_db;
    logic       m_valid;
    logic [3:0] m_dir;
    logic       m_waiting_accept;
    logic       m_waiting_release;

    function automatic logic [3:0] top_key(input logic [3:0] v);
        logic [3:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) if (v[i]) r = 4'(1 << i);
        return r;
    endfunction

    task automatic model_reset();
        m_raw1 = '1; m_raw2 = '1; m_db = '0;
        for (int i = 0; i < 4; i++) m_run[i] = 0;
        m_valid = 1'b0; m_dir = '0;
        m_waiting_accept = 1'b0; m_waiting_release = 1'b0;
    endtask

    task automatic model_step();
        logic [3:0] seen, prev_db;
        seen    = ~m_raw2;
        prev_db = m_db;
        for (int i = 0; i < 4; i++) begin
            if (seen[i] == m_db[i]) m_run[i] = 0;
            else begin
                m_run[i] = m_run[i] + 1;
                if (m_run[i] == DB) begin
                    m_db[i]  = ~m_db[i];
                    m_run[i] = 0;
                end
            end
        end
        if (m_waiting_accept) begin
            if (dir_ready) begin
                m_valid = 1'b0; m_dir = '0;
                m_waiting_accept = 1'b0; m_waiting_release = 1'b1;
            end
        end else if (m_waiting_release) begin
            if (prev_db == '0) m_waiting_release = 1'b0;
        end else if (prev_db != '0) begin
            m_valid = 1'b1; m_dir = top_key(prev_db);
            m_waiting_accept = 1'b1;
        end
        m_raw2 = m_raw1;
        m_raw1 = key_n;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: advance the model with the inputs that this edge samples, end at negedge.
    task automatic cyc();
        if (resetn) model_step(); else model_reset();
        @(posedge clock);
        @(negedge clock);
    endtask

    typedef struct {
        logic [3:0] key_n;
        logic       ready;
        logic       exp_valid;
        logic [3:0] exp_dir;
        logic [3:0] exp_db;
    } vec_t;

    vec_t vecs [17];
    int   tokens;
    int   hold_left;
    logic early;

    initial begin
        // Clean up-press: row k is applied before edge k+1 and checked after it.
        for (int k = 0; k < 17; k++) begin
            vecs[k].key_n     = (k < 10) ? 4'b0111 : 4'b1111;
            vecs[k].ready     = 1'b1;
            vecs[k].exp_valid = (k == 6);
            vecs[k].exp_dir   = (k == 6) ? 4'b1000 : 4'b0000;
            vecs[k].exp_db    = (k >= 5 && k <= 14) ? 4'b1000 : 4'b0000;
        end

        key_n = '1; dir_ready = 1'b0; resetn = 1'b0;
        model_reset();
        repeat (3) @(negedge clock);
        chk("reset_valid", 32'(dir_valid), 32'd0);
        chk("reset_dir",   32'(dir),       32'd0);
        chk("reset_db",    32'(keys_db),   32'd0);
        resetn = 1'b1;

        for (int k = 0; k < 17; k++) begin
            key_n = vecs[k].key_n; dir_ready = vecs[k].ready;
            cyc();
            chk("clean_valid", 32'(dir_valid), 32'(vecs[k].exp_valid));
            chk("clean_dir",   32'(dir),       32'(vecs[k].exp_dir));
            chk("clean_db",    32'(keys_db),   32'(vecs[k].exp_db));
        end
        repeat (3) cyc();

        // Bounce on right: 2-cycle glitches never reach the debounced level.
        dir_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            key_n = ((i / 2) % 2 == 0) ? 4'b1110 : 4'b1111;
            cyc();
            chk("bounce_valid", 32'(dir_valid),  32'd0);
            chk("bounce_db0",   32'(keys_db[0]), 32'd0);
        end
        key_n = 4'b1110;
        early = 1'b0;
        repeat (6) begin
            cyc();
            if (dir_valid) early = 1'b1;
        end
        chk("bounce_early", 32'(early), 32'd0);
        cyc();
        chk("bounce_valid7", 32'(dir_valid), 32'd1);
        chk("bounce_dir7",   32'(dir),       32'b0001);
        key_n = '1;
        repeat (12) cyc();

        // Backpressure on left with the key released before acceptance.
        dir_ready = 1'b0; key_n = 4'b1101;
        repeat (7) cyc();
        chk("bp_valid", 32'(dir_valid), 32'd1);
        chk("bp_dir",   32'(dir),       32'b0010);
        for (int i = 0; i < 10; i++) begin
            if (i == 4) key_n = '1;
            cyc();
            chk("bp_hold_valid", 32'(dir_valid), 32'd1);
            chk("bp_hold_dir",   32'(dir),       32'b0010);
        end
        dir_ready = 1'b1;
        cyc();
        chk("bp_xfer_valid", 32'(dir_valid), 32'd0);
        chk("bp_xfer_dir",   32'(dir),       32'd0);
        repeat (6) cyc();

        // Simultaneous down+right, then up added while held.
        key_n = 4'b1010;
        repeat (7) cyc();
        chk("sim_valid", 32'(dir_valid), 32'd1);
        chk("sim_dir",   32'(dir),       32'b0100);
        key_n = 4'b0010; tokens = 0;
        repeat (20) begin
            cyc();
            if (dir_valid) tokens++;
        end
        chk("sim_no_token_held", 32'(tokens), 32'd0);
        key_n = '1;
        repeat (12) begin
            cyc();
            if (dir_valid) tokens++;
        end
        chk("sim_no_token_rel", 32'(tokens), 32'd0);
        key_n = 4'b0111;
        repeat (7) cyc();
        chk("sim_up_valid", 32'(dir_valid), 32'd1);
        chk("sim_up_dir",   32'(dir),       32'b1000);
        key_n = '1;
        repeat (12) cyc();

        // Asynchronous reset while a token is pending.
        dir_ready = 1'b0; key_n = 4'b1110;
        repeat (7) cyc();
        chk("rst_pre_valid", 32'(dir_valid), 32'd1);
        #2 resetn = 1'b0;
        model_reset();
        #1;
        chk("rst_async_valid", 32'(dir_valid), 32'd0);
        chk("rst_async_dir",   32'(dir),       32'd0);
        chk("rst_async_db",    32'(keys_db),   32'd0);
        @(negedge clock);
        @(negedge clock);
        resetn = 1'b1;
        early = 1'b0;
        repeat (6) begin
            cyc();
            if (dir_valid) early = 1'b1;
        end
        chk("rst_early", 32'(early), 32'd0);
        cyc();
        chk("rst_tok_valid", 32'(dir_valid), 32'd1);
        chk("rst_tok_dir",   32'(dir),       32'b0001);
        dir_ready = 1'b1; key_n = '1;
        repeat (14) cyc();

        // Randomized key activity against the model.
        hold_left = 0;
        for (int n = 0; n < 3000; n++) begin
            if (hold_left == 0) begin
                case ($urandom_range(0, 3))
                    0:       key_n = '1;
                    1:       key_n = 4'(~(32'd1 << $urandom_range(0, 3)));
                    default: key_n = 4'($urandom);
                endcase
                hold_left = int'($urandom_range(1, 14));
            end
            hold_left--;
            dir_ready = ($urandom_range(0, 3) != 0);
            cyc();
            chk("rand_outputs", 32'({dir_valid, dir, keys_db}), 32'({m_valid, m_dir, m_db}));
            chk("rand_onehot", 32'($countones(dir) <= 1 && (dir_valid || dir == '0)), 32'd1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
